// File: rtl/bram_stream_reader.sv
// rtl/bram_stream_reader.sv - block reader from BRAM port B onto a valid/ready stream
// Credit-gated reads feed a small skid FIFO so sink backpressure never drops data.

module bram_stream_fifo #(
  parameter int WIDTH = 33,
  parameter int DEPTH = 3,
  parameter int CW    = $clog2(DEPTH + 1)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             push,
  input  logic [WIDTH-1:0] push_data,
  input  logic             pop,
  output logic [WIDTH-1:0] head,
  output logic [CW-1:0]    count
);
  localparam int PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

  logic [WIDTH-1:0] mem [DEPTH];
  logic [PW-1:0]    wr_ptr;
  logic [PW-1:0]    rd_ptr;

  assign head = mem[rd_ptr];

  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
      for (int i = 0; i < DEPTH; i++) mem[i] <= '0;
    end else begin
      if (push) begin
        mem[wr_ptr] <= push_data;
        wr_ptr      <= (wr_ptr == PW'(DEPTH - 1)) ? '0 : wr_ptr + PW'(1);
      end
      if (pop) rd_ptr <= (rd_ptr == PW'(DEPTH - 1)) ? '0 : rd_ptr + PW'(1);
      count <= count + CW'(push) - CW'(pop);
    end
  end
endmodule

module bram_stream_reader #(
  parameter int ADDR_W = 13,
  parameter int DATA_W = 32,
  parameter int RD_LAT = 1
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                start,
  input  logic [ADDR_W-1:0]   base_addr,
  input  logic [ADDR_W:0]     len,
  output logic                busy,
  output logic                done,
  output logic [ADDR_W-1:0]   bram_addr,
  output logic                bram_en,
  output logic [DATA_W/8-1:0] bram_we,
  output logic [DATA_W-1:0]   bram_din,
  input  logic [DATA_W-1:0]   bram_dout,
  output logic [DATA_W-1:0]   m_data,
  output logic                m_valid,
  input  logic                m_ready,
  output logic                m_last
);
  localparam int DEPTH = RD_LAT + 2;
  localparam int CW    = $clog2(DEPTH + 1);
  localparam int LW    = ADDR_W + 1;
  localparam logic [LW-1:0] MAX_LEN = {1'b1, {ADDR_W{1'b0}}};

  typedef enum logic [1:0] {IDLE, READ, DRAIN, DONE} state_t;

  state_t          state;
  logic [LW-1:0]   issue_left;
  logic [LW-1:0]   issue_left_next;
  logic [LW-1:0]   len_sat;
  logic [RD_LAT-1:0] pipe_v;
  logic [RD_LAT-1:0] pipe_l;
  logic [RD_LAT-1:0] pipe_v_next;
  logic [RD_LAT-1:0] pipe_l_next;
  logic            last_issue;
  logic            push;
  logic            pop;
  logic [CW-1:0]   fifo_count;
  logic [CW-1:0]   count_next;
  logic [DATA_W:0] fifo_head;
  logic            credit_ok;

  assign bram_we  = '0;
  assign bram_din = '0;

  // Each tracked read carries a flag marking the final word of the transfer.
  assign push    = pipe_v[RD_LAT-1];
  assign m_valid = (fifo_count != '0);
  assign m_data  = fifo_head[DATA_W-1:0];
  assign m_last  = m_valid & fifo_head[DATA_W];
  assign pop     = m_valid & m_ready;

  bram_stream_fifo #(
    .WIDTH (DATA_W + 1),
    .DEPTH (DEPTH),
    .CW    (CW)
  ) u_fifo (
    .clk       (clk),
    .rst       (rst),
    .push      (push),
    .push_data ({pipe_l[RD_LAT-1], bram_dout}),
    .pop       (pop),
    .head      (fifo_head),
    .count     (fifo_count)
  );

  // bram_en is registered, so credits are judged on next-cycle occupancy.
  always_comb begin
    len_sat         = (len > MAX_LEN) ? MAX_LEN : len;
    last_issue      = bram_en && (issue_left == LW'(1));
    issue_left_next = issue_left - LW'(bram_en);
    pipe_v_next     = RD_LAT'({pipe_v, bram_en});
    pipe_l_next     = RD_LAT'({pipe_l, last_issue});
    count_next      = fifo_count + CW'(push) - CW'(pop);
    credit_ok       = (issue_left_next != '0) &&
                      (($countones(pipe_v_next) + int'(count_next)) < DEPTH);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state      <= IDLE;
      busy       <= 1'b0;
      done       <= 1'b0;
      bram_en    <= 1'b0;
      bram_addr  <= '0;
      issue_left <= '0;
      pipe_v     <= '0;
      pipe_l     <= '0;
    end else begin
      done    <= 1'b0;
      bram_en <= 1'b0;
      pipe_v  <= pipe_v_next;
      pipe_l  <= pipe_l_next;
      if (bram_en) begin
        bram_addr  <= bram_addr + ADDR_W'(1);
        issue_left <= issue_left_next;
      end
      case (state)
        IDLE: begin
          if (start) begin
            busy      <= 1'b1;
            bram_addr <= base_addr;
            if (len == '0) begin
              state <= DONE;
              done  <= 1'b1;
            end else begin
              state      <= READ;
              issue_left <= len_sat;
              bram_en    <= 1'b1;
            end
          end
        end
        READ: begin
          if (issue_left_next == '0) state <= DRAIN;
          else bram_en <= credit_ok;
        end
        DRAIN: begin
          if (pop && m_last) begin
            state <= DONE;
            done  <= 1'b1;
          end
        end
        DONE: begin
          state <= IDLE;
          busy  <= 1'b0;
        end
        default: state <= IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_bram_stream_reader.sv
// tb/tb_bram_stream_reader.sv - directed checks of bram_stream_reader at RD_LAT 1 and 2
module tb_bram_stream_reader;
  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        start = 1'b0;
  logic        m_ready = 1'b1;
  logic [12:0] base = '0;
  logic [13:0] len = '0;
  logic [3:0]  rpat = 4'b1001;
  logic        clr = 1'b0;
  int          cyc = 0;
  int          checks = 0;
  int          errors = 0;

  logic        busy [2];
  logic        done [2];
  logic        bram_en [2];
  logic        m_valid [2];
  logic        m_last [2];
  logic [12:0] bram_addr [2];
  logic [3:0]  bram_we [2];
  logic [31:0] bram_din [2];
  logic [31:0] bram_dout [2];
  logic [31:0] m_data [2];
  logic [31:0] mem [8192];

  int en_cnt [2], popped [2], done_cnt [2], busy_cnt [2], n_last [2], last_idx [2];
  int last_cyc [2], first_en_cyc [2], first_valid_cyc [2], done_cyc [2];
  int max_out [2], stall_err [2];
  logic        prev_stall [2];
  logic        prev_last [2];
  logic [31:0] prev_data [2];
  logic [12:0] addr_log [2][64];
  logic [31:0] data_log [2][64];

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  function automatic logic [31:0] exp_word(input int a);
    if (a >= 16 && a < 20) return 32'hA0 + 32'(a - 16);
    return {16'hC0DE, 3'b000, 13'(a)};
  endfunction

  for (genvar g = 0; g < 2; g++) begin : g_dut
    logic [31:0] q1, q2;
    always @(posedge clk) begin
      if (bram_en[g]) q1 <= mem[bram_addr[g]];
      q2 <= q1;
    end
    assign bram_dout[g] = (g == 0) ? q1 : q2;

    bram_stream_reader #(.ADDR_W(13), .DATA_W(32), .RD_LAT(g + 1)) dut (
      .clk(clk), .rst(rst), .start(start), .base_addr(base), .len(len),
      .busy(busy[g]), .done(done[g]), .bram_addr(bram_addr[g]), .bram_en(bram_en[g]),
      .bram_we(bram_we[g]), .bram_din(bram_din[g]), .bram_dout(bram_dout[g]),
      .m_data(m_data[g]), .m_valid(m_valid[g]), .m_ready(m_ready), .m_last(m_last[g])
    );
  end

  always @(negedge clk) begin
    for (int g = 0; g < 2; g++) begin
      if (clr) begin
        en_cnt[g] = 0; popped[g] = 0; done_cnt[g] = 0; busy_cnt[g] = 0; n_last[g] = 0;
        last_idx[g] = -1; last_cyc[g] = -1; first_en_cyc[g] = -1; first_valid_cyc[g] = -1;
        done_cyc[g] = -1; max_out[g] = 0; stall_err[g] = 0; prev_stall[g] = 1'b0;
      end else begin
        if (busy[g]) busy_cnt[g]++;
        if (bram_en[g]) begin
          if (en_cnt[g] == 0) first_en_cyc[g] = cyc;
          if (en_cnt[g] < 64) addr_log[g][en_cnt[g]] = bram_addr[g];
          en_cnt[g]++;
        end
        if (en_cnt[g] - popped[g] > max_out[g]) max_out[g] = en_cnt[g] - popped[g];
        if (prev_stall[g] && (!m_valid[g] || m_data[g] !== prev_data[g] || m_last[g] !== prev_last[g]))
          stall_err[g]++;
        prev_stall[g] = m_valid[g] && !m_ready;
        prev_data[g]  = m_data[g];
        prev_last[g]  = m_last[g];
        if (m_valid[g] && first_valid_cyc[g] < 0) first_valid_cyc[g] = cyc;
        if (m_valid[g] && m_ready) begin
          if (popped[g] < 64) data_log[g][popped[g]] = m_data[g];
          if (m_last[g]) begin n_last[g]++; last_idx[g] = popped[g]; last_cyc[g] = cyc; end
          popped[g]++;
        end
        if (done[g]) begin done_cnt[g]++; done_cyc[g] = cyc; end
      end
    end
  end

  task automatic clear_mon();
    clr = 1'b1;
    @(negedge clk);
    @(posedge clk); #1;
    clr = 1'b0;
  endtask

  task automatic xfer(input logic [12:0] b, input logic [13:0] l, input bit bp,
                      input int restart_at, input int tmo, output int s);
    clear_mon();
    start = 1'b1; base = b; len = l; s = cyc;
    for (int i = 0; i < tmo; i++) begin
      if (i == restart_at) begin start = 1'b1; base = 13'h0500; len = 14'd2; end
      m_ready = bp ? rpat[i % 4] : 1'b1;
      @(posedge clk); #1;
      start = 1'b0;
      if (done_cnt[0] != 0 && done_cnt[1] != 0) break;
    end
    m_ready = 1'b1;
    repeat (3) @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    repeat (3) @(posedge clk);
    #1;
    for (int g = 0; g < 2; g++) begin
      checks++;
      if ({busy[g], done[g], bram_en[g], m_valid[g], m_last[g]} !== 5'b0) begin
        errors++; $display("FAIL reset_flags inst=%0d got=%b exp=00000", g,
                           {busy[g], done[g], bram_en[g], m_valid[g], m_last[g]});
      end
      checks++;
      if (bram_addr[g] !== 13'h0 || m_data[g] !== 32'h0 || bram_we[g] !== 4'h0 || bram_din[g] !== 32'h0) begin
        errors++; $display("FAIL reset_buses inst=%0d got addr=%h data=%h we=%h din=%h exp=0", g,
                           bram_addr[g], m_data[g], bram_we[g], bram_din[g]);
      end
    end
    rst = 1'b0;
  endtask

  task automatic test_basic();
    int s;
    xfer(13'h0010, 14'd4, 1'b0, -1, 40, s);
    for (int g = 0; g < 2; g++) begin
      checks++;
      if (popped[g] != 4) begin errors++; $display("FAIL basic_count inst=%0d got=%0d exp=4", g, popped[g]); end
      for (int i = 0; i < 4; i++) begin
        checks++;
        if (data_log[g][i] !== exp_word(16 + i)) begin
          errors++; $display("FAIL basic_data[%0d] inst=%0d got=%h exp=%h", i, g, data_log[g][i], exp_word(16 + i));
        end
      end
      checks++;
      if (n_last[g] != 1 || last_idx[g] != 3) begin
        errors++; $display("FAIL basic_last inst=%0d got=%0d lasts at %0d exp=1 at 3", g, n_last[g], last_idx[g]);
      end
      checks++;
      if (first_en_cyc[g] != s + 1) begin
        errors++; $display("FAIL basic_first_en inst=%0d got=%0d exp=%0d", g, first_en_cyc[g], s + 1);
      end
      checks++;
      if (first_valid_cyc[g] != s + 3 + g) begin
        errors++; $display("FAIL basic_first_valid inst=%0d got=%0d exp=%0d", g, first_valid_cyc[g], s + 3 + g);
      end
      checks++;
      if (last_cyc[g] != s + 6 + g) begin
        errors++; $display("FAIL basic_gapless inst=%0d got=%0d exp=%0d", g, last_cyc[g], s + 6 + g);
      end
      checks++;
      if (done_cnt[g] != 1 || done_cyc[g] != s + 7 + g) begin
        errors++; $display("FAIL basic_done inst=%0d got=%0d@%0d exp=1@%0d", g, done_cnt[g], done_cyc[g], s + 7 + g);
      end
      checks++;
      if (en_cnt[g] != 4) begin errors++; $display("FAIL basic_en_cycles inst=%0d got=%0d exp=4", g, en_cnt[g]); end
    end
  endtask

  task automatic test_wrap();
    int s;
    logic [12:0] wa [4] = '{13'h1FFE, 13'h1FFF, 13'h0000, 13'h0001};
    xfer(13'h1FFE, 14'd4, 1'b0, -1, 40, s);
    for (int g = 0; g < 2; g++) begin
      for (int i = 0; i < 4; i++) begin
        checks++;
        if (addr_log[g][i] !== wa[i] || data_log[g][i] !== exp_word(int'(wa[i]))) begin
          errors++; $display("FAIL wrap[%0d] inst=%0d got=%h/%h exp=%h/%h", i, g, addr_log[g][i],
                             data_log[g][i], wa[i], exp_word(int'(wa[i])));
        end
      end
      checks++;
      if (en_cnt[g] != 4 || done_cnt[g] != 1) begin
        errors++; $display("FAIL wrap_counts inst=%0d got en=%0d done=%0d exp en=4 done=1", g, en_cnt[g], done_cnt[g]);
      end
    end
  endtask

  task automatic test_backpressure();
    int s;
    xfer(13'h0100, 14'd16, 1'b1, -1, 200, s);
    for (int g = 0; g < 2; g++) begin
      checks++;
      if (popped[g] != 16 || done_cnt[g] != 1) begin
        errors++; $display("FAIL bp_count inst=%0d got=%0d done=%0d exp=16 done=1", g, popped[g], done_cnt[g]);
      end
      for (int i = 0; i < 16; i++) begin
        checks++;
        if (data_log[g][i] !== exp_word(256 + i)) begin
          errors++; $display("FAIL bp_data[%0d] inst=%0d got=%h exp=%h", i, g, data_log[g][i], exp_word(256 + i));
        end
      end
      checks++;
      if (stall_err[g] != 0) begin errors++; $display("FAIL bp_stable inst=%0d got=%0d exp=0", g, stall_err[g]); end
      checks++;
      if (max_out[g] > g + 3) begin errors++; $display("FAIL bp_credit inst=%0d got=%0d exp<=%0d", g, max_out[g], g + 3); end
      checks++;
      if (n_last[g] != 1 || last_idx[g] != 15) begin
        errors++; $display("FAIL bp_last inst=%0d got=%0d at %0d exp=1 at 15", g, n_last[g], last_idx[g]);
      end
    end
  endtask

  task automatic test_len_zero();
    int s;
    xfer(13'h0040, 14'd0, 1'b0, -1, 20, s);
    for (int g = 0; g < 2; g++) begin
      checks++;
      if (en_cnt[g] != 0 || popped[g] != 0) begin
        errors++; $display("FAIL len0_reads inst=%0d got en=%0d words=%0d exp=0", g, en_cnt[g], popped[g]);
      end
      checks++;
      if (done_cnt[g] != 1 || done_cyc[g] != s + 1) begin
        errors++; $display("FAIL len0_done inst=%0d got=%0d@%0d exp=1@%0d", g, done_cnt[g], done_cyc[g], s + 1);
      end
      checks++;
      if (busy_cnt[g] != 1) begin errors++; $display("FAIL len0_busy inst=%0d got=%0d exp=1", g, busy_cnt[g]); end
    end
  endtask

  task automatic test_start_ignored();
    int s;
    xfer(13'h0400, 14'd6, 1'b0, 2, 60, s);
    for (int g = 0; g < 2; g++) begin
      checks++;
      if (en_cnt[g] != 6 || popped[g] != 6 || done_cnt[g] != 1) begin
        errors++; $display("FAIL restart_counts inst=%0d got en=%0d words=%0d done=%0d exp 6/6/1", g,
                           en_cnt[g], popped[g], done_cnt[g]);
      end
      for (int i = 0; i < 6; i++) begin
        checks++;
        if (addr_log[g][i] !== 13'(1024 + i) || data_log[g][i] !== exp_word(1024 + i)) begin
          errors++; $display("FAIL restart_word[%0d] inst=%0d got=%h/%h exp=%h/%h", i, g, addr_log[g][i],
                             data_log[g][i], 13'(1024 + i), exp_word(1024 + i));
        end
      end
      checks++;
      if (last_idx[g] != 5) begin errors++; $display("FAIL restart_last inst=%0d got=%0d exp=5", g, last_idx[g]); end
    end
  endtask

  task automatic test_reset_mid();
    int s, k;
    int snap [2];
    clear_mon();
    start = 1'b1; base = 13'h0200; len = 14'd8; m_ready = 1'b1;
    k = 0;
    while (popped[0] < 3 && k < 50) begin
      @(posedge clk); #1;
      start = 1'b0;
      k++;
    end
    checks++;
    if (popped[0] != 3) begin errors++; $display("FAIL rstmid_reach got=%0d exp=3", popped[0]); end
    rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
    @(negedge clk);
    for (int g = 0; g < 2; g++) begin
      snap[g] = popped[g];
      checks++;
      if ({m_valid[g], bram_en[g], busy[g]} !== 3'b000) begin
        errors++; $display("FAIL rstmid_flush inst=%0d got=%b exp=000", g, {m_valid[g], bram_en[g], busy[g]});
      end
    end
    repeat (10) @(posedge clk);
    #1;
    for (int g = 0; g < 2; g++) begin
      checks++;
      if (done_cnt[g] != 0 || popped[g] != snap[g]) begin
        errors++; $display("FAIL rstmid_quiet inst=%0d got done=%0d words=%0d exp done=0 words=%0d", g,
                           done_cnt[g], popped[g], snap[g]);
      end
    end
    xfer(13'h0300, 14'd2, 1'b0, -1, 40, s);
    for (int g = 0; g < 2; g++) begin
      checks++;
      if (popped[g] != 2 || done_cnt[g] != 1 || last_idx[g] != 1) begin
        errors++; $display("FAIL rstmid_restart inst=%0d got words=%0d done=%0d last=%0d exp 2/1/1", g,
                           popped[g], done_cnt[g], last_idx[g]);
      end
      for (int i = 0; i < 2; i++) begin
        checks++;
        if (data_log[g][i] !== exp_word(768 + i)) begin
          errors++; $display("FAIL rstmid_data[%0d] inst=%0d got=%h exp=%h", i, g, data_log[g][i], exp_word(768 + i));
        end
      end
    end
  endtask

  task automatic test_saturate();
    int s;
    xfer(13'h0000, 14'h2005, 1'b0, -1, 8400, s);
    for (int g = 0; g < 2; g++) begin
      checks++;
      if (en_cnt[g] != 8192 || popped[g] != 8192) begin
        errors++; $display("FAIL sat_count inst=%0d got en=%0d words=%0d exp=8192", g, en_cnt[g], popped[g]);
      end
      checks++;
      if (n_last[g] != 1 || last_idx[g] != 8191 || done_cnt[g] != 1) begin
        errors++; $display("FAIL sat_end inst=%0d got last=%0d@%0d done=%0d exp 1@8191 done=1", g,
                           n_last[g], last_idx[g], done_cnt[g]);
      end
      checks++;
      if (data_log[g][20] !== exp_word(20)) begin
        errors++; $display("FAIL sat_data inst=%0d got=%h exp=%h", g, data_log[g][20], exp_word(20));
      end
    end
  endtask

  initial begin
    for (int a = 0; a < 8192; a++) mem[a] = exp_word(a);
    test_reset();
    test_basic();
    test_wrap();
    test_backpressure();
    test_len_zero();
    test_start_ignored();
    test_reset_mid();
    test_saturate();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog got=timeout exp=finish");
    $fatal(1);
  end
endmodule
